// File: rtl/multi_queue_output_arbiter.sv
// rtl/multi_queue_output_arbiter.sv - round-robin packet-locking arbiter merging queue streams onto one link
// Grants one queue per packet, holds it to the last flit, and drives a registered output stage.
module multi_queue_output_arbiter #(
    parameter int QUEUE_COUNT = 4,
    parameter int DATA_WIDTH  = 32,
    localparam int QID_WIDTH  = (QUEUE_COUNT > 1) ? $clog2(QUEUE_COUNT) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [QUEUE_COUNT-1:0]                queue_enable,
    input  logic [QUEUE_COUNT-1:0]                in_valid,
    output logic [QUEUE_COUNT-1:0]                in_ready,
    input  logic [QUEUE_COUNT-1:0][DATA_WIDTH-1:0] in_data,
    input  logic [QUEUE_COUNT-1:0]                in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_last,
    output logic [QID_WIDTH-1:0]                  out_queue,
    output logic                                  busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_next;
    logic [QID_WIDTH-1:0]   cur, cur_next;
    logic [QID_WIDTH-1:0]   last_grant, last_grant_next;
    logic [QID_WIDTH-1:0]   winner, sel;
    logic [QUEUE_COUNT-1:0] cand;
    logic                   found, load, xfer, busy_next;

    assign load = !out_valid || out_ready;
    assign cand = in_valid & queue_enable;

    // Circular search starting just after the previous grant.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= QUEUE_COUNT; k++) begin
            if (!found && cand[QID_WIDTH'((int'(last_grant) + k) % QUEUE_COUNT)]) begin
                found  = 1'b1;
                winner = QID_WIDTH'((int'(last_grant) + k) % QUEUE_COUNT);
            end
        end
    end

    always_comb begin
        state_next      = state;
        cur_next        = cur;
        last_grant_next = last_grant;
        busy_next       = busy;
        in_ready        = '0;
        sel             = (state == IDLE) ? winner : cur;
        // A locked queue keeps its ready even while its valid is low, so the lock is never lost.
        if (load && (state == LOCKED || found)) begin
            in_ready[sel] = 1'b1;
        end
        xfer = in_valid[sel] && in_ready[sel];
        if (xfer) begin
            if (state == IDLE) begin
                last_grant_next = winner;
            end
            cur_next   = sel;
            state_next = in_last[sel] ? IDLE : LOCKED;
            busy_next  = !in_last[sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            last_grant <= QID_WIDTH'(QUEUE_COUNT - 1);
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cur        <= cur_next;
            last_grant <= last_grant_next;
            busy       <= busy_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_queue <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[sel];
            out_last  <= in_last[sel];
            out_queue <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_queue_output_arbiter.sv
// tb/tb_multi_queue_output_arbiter.sv - scoreboard bench for multi_queue_output_arbiter
// Per-queue source FIFOs feed the DUT; a monitor pops expected flits whenever the output handshakes.
module tb_multi_queue_output_arbiter;

    localparam int QC = 4;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [QC-1:0]        queue_enable;
    logic [QC-1:0]        in_valid;
    logic [QC-1:0]        in_ready;
    logic [QC-1:0][DW-1:0] in_data;
    logic [QC-1:0]        in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic                 out_last;
    logic [1:0]           out_queue;
    logic                 busy;

    logic [DW:0]          src [QC][$];
    logic [DW+2:0]        exp_q [$];
    logic [DW+2:0]        mon_e;
    logic [QC-1:0]        stall;
    int                   errors = 0;
    int                   checks = 0;

    always #5 clk = ~clk;

    multi_queue_output_arbiter #(.QUEUE_COUNT(QC), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .queue_enable(queue_enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_queue(out_queue), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic add(input int q, input logic [DW-1:0] d, input logic l, input bit expected);
        src[q].push_back({l, d});
        if (expected) exp_q.push_back({2'(q), l, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int q = 0; q < QC; q++) src[q].delete();
        exp_q.delete();
        stall        = '0;
        queue_enable = '1;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    // Source driver: presents queue heads, pops the ones accepted at the previous edge.
    initial begin
        logic [QC-1:0] acc;
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        forever begin
            @(negedge clk);
            acc = rst ? '0 : (in_valid & in_ready);
            checks++;
            if (!$onehot0(in_ready) || (out_valid && !out_ready && in_ready != '0)) begin
                errors++;
                $display("FAIL in_ready_legal: in_ready=%b out_valid=%b out_ready=%b required onehot0 and zero when stalled",
                         in_ready, out_valid, out_ready);
            end
            @(posedge clk);
            #1;
            for (int q = 0; q < QC; q++) begin
                if (acc[q] && src[q].size() > 0) void'(src[q].pop_front());
                if (src[q].size() > 0) begin
                    in_valid[q] = !stall[q];
                    {in_last[q], in_data[q]} = src[q][0];
                end else begin
                    in_valid[q] = 1'b0;
                    in_last[q]  = 1'b0;
                    in_data[q]  = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("busy_vs_last", 64'(busy), 64'(!out_last));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", 64'({out_queue, out_last, out_data}), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_flit", 64'({out_queue, out_last, out_data}), 64'(mon_e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        stall        = '0;
        queue_enable = '1;
        out_ready    = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_queue", 64'(out_queue), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);

        // Single 3-flit packet from queue 2.
        do_reset();
        add(2, 32'hA000_0000, 1'b0, 1'b1);
        add(2, 32'hA000_0001, 1'b0, 1'b1);
        add(2, 32'hA000_0002, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("t1_no_early_valid", 64'(out_valid), 64'd0);
        check("t1_in_ready",       64'(in_ready),  64'h4);
        @(negedge clk);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_out_queue", 64'(out_queue), 64'd2);
        check("t1_busy_a0",   64'(busy),      64'd1);
        @(negedge clk);
        check("t1_busy_a1",   64'(busy),      64'd1);
        @(negedge clk);
        check("t1_busy_a2",   64'(busy),      64'd0);
        check("t1_last_a2",   64'(out_last),  64'd1);
        wait_drain("t1", 20);

        // All queues, two 2-flit packets each: strict rotation at full rate.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int q = 0; q < QC; q++)
                for (int f = 0; f < 2; f++)
                    add(q, 32'h2000_0000 | (q << 8) | (p << 4) | f, f == 1, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        repeat (16) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        check("t2_full_rate", 64'(cnt), 64'd16);
        wait_drain("t2", 40);

        // Queue 1 stalls mid-packet while queue 0 waits.
        do_reset();
        for (int f = 0; f < 4; f++) add(1, 32'hB000_0000 | f, f == 3, 1'b1);
        tick();
        tick();
        stall[1] = 1'b1;
        add(0, 32'hC000_0000, 1'b1, 1'b1);
        tick();
        repeat (3) begin
            @(negedge clk);
            check("t3_busy_hold",  64'(busy),        64'd1);
            check("t3_no_q0_grant", 64'(in_ready[0]), 64'd0);
        end
        stall[1] = 1'b0;
        wait_drain("t3", 30);

        // Output backpressure holds the registered flit.
        do_reset();
        out_ready = 1'b0;
        add(3, 32'hDEAD_BEEF, 1'b1, 1'b1);
        add(3, 32'h1234_5678, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_data",  64'(out_data),  64'hDEAD_BEEF);
            check("t4_hold_last",  64'(out_last),  64'd1);
            check("t4_hold_queue", 64'(out_queue), 64'd3);
            check("t4_hold_ready", 64'(in_ready),  64'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_reload_ready", 64'(in_ready), 64'h8);
        @(negedge clk);
        check("t4_reload_valid", 64'(out_valid), 64'd1);
        check("t4_reload_data",  64'(out_data),  64'h1234_5678);
        wait_drain("t4", 20);

        // Enable mask excludes queue 2.
        do_reset();
        queue_enable = 4'b1011;
        for (int p = 0; p < 2; p++)
            for (int q = 0; q < QC; q++)
                for (int f = 0; f < 2; f++)
                    add(q, 32'h5000_0000 | (q << 8) | (p << 4) | f, f == 1, q != 2);
        wait_drain("t5a", 40);
        repeat (6) @(negedge clk);

        // Disabling the locked queue mid-packet does not truncate it.
        do_reset();
        queue_enable = 4'b1011;
        for (int f = 0; f < 4; f++) add(1, 32'hD000_0000 | f, f == 3, 1'b1);
        add(2, 32'hD200_0000, 1'b1, 1'b0);
        tick();
        tick();
        queue_enable[1] = 1'b0;
        add(0, 32'hE000_0000, 1'b1, 1'b1);
        wait_drain("t5b", 30);
        repeat (4) @(negedge clk);
        check("t5_q2_never_taken", 64'(src[2].size()), 64'd1);

        // Reset mid-packet, then queue 0 has first priority again.
        do_reset();
        add(2, 32'hF000_0000, 1'b0, 1'b1);
        add(2, 32'hF000_0001, 1'b0, 1'b0);
        add(2, 32'hF000_0002, 1'b0, 1'b0);
        add(2, 32'hF000_0003, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_busy",      64'(busy),      64'd0);
        check("t6_first_seen",    64'(exp_q.size()), 64'd0);
        do_reset();
        add(0, 32'h6000_0000, 1'b1, 1'b1);
        add(2, 32'h6200_0000, 1'b1, 1'b1);
        wait_drain("t6", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
